// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Byte FIFO plus frame sequencer feeding a UART transmitter. Bytes arrive at
// up to one per clock, are buffered, and are handed to the transmitter one at
// a time over a start-pulse / done-pulse handshake. Payload bytes are counted
// into frames of FRAME_LEN so the host can delimit each block.
//
// Build option: define UART_TX_FEEDER_CHECKSUM_EN to append a mod-256 sum of
// each frame's payload as one extra byte after the last payload byte.
//
// Parameters
//   DEPTH        FIFO entries (power of 2, >= 2)
//   FRAME_LEN    payload bytes per frame (>= 1)
// Ports
//   i_Clock       system clock, rising edge
//   i_Rst_n       asynchronous active-low reset
//   i_Wr_DV       write strobe, one byte per cycle
//   i_Wr_Byte     write data
//   o_Full        FIFO holds DEPTH entries (registered)
//   o_Empty       FIFO holds no entries (registered)
//   o_Overflow    sticky: a write arrived while full
//   o_Tx_DV       one-cycle start pulse to the transmitter
//   o_Tx_Byte     byte for the transmitter, held until the next pulse
//   i_Tx_Active   transmitter busy
//   i_Tx_Done     transmitter one-cycle completion pulse
//   o_Frame_Done  one-cycle pulse after the last byte of a frame completes
module uart_tx_feeder #(
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 512
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Wr_DV,
    input  logic [7:0] i_Wr_Byte,
    output logic       o_Full,
    output logic       o_Empty,
    output logic       o_Overflow,
    output logic       o_Tx_DV,
    output logic [7:0] o_Tx_Byte,
    input  logic       i_Tx_Active,
    input  logic       i_Tx_Done,
    output logic       o_Frame_Done
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN);

`ifdef UART_TX_FEEDER_CHECKSUM_EN
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT      = 2'd1,
        S_CSUM      = 2'd2,
        S_CSUM_WAIT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1
    } state_t;
`endif

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   w_wr_ptr_next;
    logic [PW-1:0]   w_rd_ptr_next;
    logic            r_full;
    logic            r_empty;
    logic            r_overflow;
    logic            r_tx_dv;
    logic [7:0]      r_tx_byte;
    logic            r_frame_done;
    logic [CW-1:0]   r_count;
    logic            w_tx_dv_next;
    logic [7:0]      w_tx_byte_next;
    logic            w_frame_done_next;
    logic [CW-1:0]   w_count_next;
    logic            w_pop;
    logic            w_guard;
    logic            w_wr_accept;
    logic            w_full_next;
    logic            w_empty_next;
    logic [7:0]      w_head;
    logic [7:0]      w_mem [DEPTH];
`ifdef UART_TX_FEEDER_CHECKSUM_EN
    logic [7:0]      r_sum;
    logic [7:0]      w_sum_next;
`endif

    // Storage: one register per entry, written only when the write pointer
    // selects it. No reset; contents are meaningless until written.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            logic [7:0] r_entry;
            always_ff @(posedge i_Clock) begin
                if (w_wr_accept && (r_wr_ptr[AW-1:0] == AW'(gi))) begin
                    r_entry <= i_Wr_Byte;
                end
            end
            assign w_mem[gi] = r_entry;
        end
    endgenerate

    assign w_head = w_mem[r_rd_ptr[AW-1:0]];

    // Never start while the transmitter is busy or in its done/cleanup cycle.
    assign w_guard = !i_Tx_Active && !i_Tx_Done;

    // Full is judged on the registered flag, so a write while full is dropped
    // even if a pop frees a slot on the same edge.
    assign w_wr_accept   = i_Wr_DV && !r_full;
    assign w_wr_ptr_next = w_wr_accept ? (r_wr_ptr + PW'(1)) : r_wr_ptr;
    assign w_rd_ptr_next = w_pop ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
    assign w_full_next   = (w_wr_ptr_next[AW] != w_rd_ptr_next[AW]) &&
                           (w_wr_ptr_next[AW-1:0] == w_rd_ptr_next[AW-1:0]);
    assign w_empty_next  = (w_wr_ptr_next == w_rd_ptr_next);

    always_comb begin
        w_state_next      = r_state;
        w_tx_dv_next      = 1'b0;
        w_tx_byte_next    = r_tx_byte;
        w_frame_done_next = 1'b0;
        w_count_next      = r_count;
        w_pop             = 1'b0;
`ifdef UART_TX_FEEDER_CHECKSUM_EN
        w_sum_next        = r_sum;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_empty && w_guard) begin
                    w_pop          = 1'b1;
                    w_tx_byte_next = w_head;
                    w_tx_dv_next   = 1'b1;
                    w_count_next   = r_count + CW'(1);
`ifdef UART_TX_FEEDER_CHECKSUM_EN
                    w_sum_next     = r_sum + w_head;
`endif
                    w_state_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_Tx_Done) begin
                    if (r_count < FRAME_LAST) begin
                        w_state_next = S_IDLE;
                    end else begin
`ifdef UART_TX_FEEDER_CHECKSUM_EN
                        w_state_next = S_CSUM;
`else
                        w_frame_done_next = 1'b1;
                        w_count_next      = '0;
                        w_state_next      = S_IDLE;
`endif
                    end
                end
            end
`ifdef UART_TX_FEEDER_CHECKSUM_EN
            S_CSUM: begin
                if (w_guard) begin
                    w_tx_byte_next = r_sum;
                    w_tx_dv_next   = 1'b1;
                    w_state_next   = S_CSUM_WAIT;
                end
            end
            S_CSUM_WAIT: begin
                if (i_Tx_Done) begin
                    w_frame_done_next = 1'b1;
                    w_count_next      = '0;
                    w_sum_next        = '0;
                    w_state_next      = S_IDLE;
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_overflow   <= 1'b0;
            r_tx_dv      <= 1'b0;
            r_tx_byte    <= 8'h00;
            r_frame_done <= 1'b0;
            r_count      <= '0;
`ifdef UART_TX_FEEDER_CHECKSUM_EN
            r_sum        <= 8'h00;
`endif
        end else begin
            r_state      <= w_state_next;
            r_wr_ptr     <= w_wr_ptr_next;
            r_rd_ptr     <= w_rd_ptr_next;
            r_full       <= w_full_next;
            r_empty      <= w_empty_next;
            r_tx_dv      <= w_tx_dv_next;
            r_tx_byte    <= w_tx_byte_next;
            r_frame_done <= w_frame_done_next;
            r_count      <= w_count_next;
`ifdef UART_TX_FEEDER_CHECKSUM_EN
            r_sum        <= w_sum_next;
`endif
            if (i_Wr_DV && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_Full       = r_full;
    assign o_Empty      = r_empty;
    assign o_Overflow   = r_overflow;
    assign o_Tx_DV      = r_tx_dv;
    assign o_Tx_Byte    = r_tx_byte;
    assign o_Frame_Done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Testbench for uart_tx_feeder: a behavioural transmitter drives the
// Active/Done handshake, a frame model predicts the byte stream (payload plus
// optional per-frame checksum) into a queue, and a monitor pops and compares
// on every start pulse.
module tb_uart_tx_feeder;
    localparam int DEPTH     = 16;
    localparam int FRAME_LEN = 4;

    logic       clk = 1'b0;
    logic       i_Rst_n = 1'b0;
    logic       i_Wr_DV = 1'b0;
    logic [7:0] i_Wr_Byte = 8'h00;
    logic       o_Full, o_Empty, o_Overflow, o_Tx_DV, o_Frame_Done;
    logic [7:0] o_Tx_Byte;
    logic       i_Tx_Active, i_Tx_Done;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (i_Rst_n),
        .i_Wr_DV     (i_Wr_DV),
        .i_Wr_Byte   (i_Wr_Byte),
        .o_Full      (o_Full),
        .o_Empty     (o_Empty),
        .o_Overflow  (o_Overflow),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .i_Tx_Active (i_Tx_Active),
        .i_Tx_Done   (i_Tx_Done),
        .o_Frame_Done(o_Frame_Done)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       fend;
        logic       csum;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // frame model
    int m_cnt = 0;
    int m_sum = 0;
    int wr_total = 0;

    // transmitter model / monitor state
    logic xm_busy = 1'b0;
    logic xm_done = 1'b0;
    logic hold_active = 1'b0;
    int   xm_left = 0;
    int   xm_len_fixed = 100;   // 10 clocks per bit x 10 bits; 0 = random
    logic xm_flag = 1'b0;
    logic fd_pending = 1'b0;
    logic fd_flag = 1'b0;
    int   fd_seen = 0;
    int   fd_exp = 0;
    int   payload_dv = 0;
    int   dv_total = 0;
    logic act_prev = 1'b0;
    logic done_prev = 1'b0;

    assign i_Tx_Active = xm_busy | hold_active;
    assign i_Tx_Done   = xm_done;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Frame model: each payload byte counts toward FRAME_LEN; the frame end is
    // either the last payload byte or the appended sum byte.
    task automatic model_push(input logic [7:0] b);
        exp_t e;
        m_cnt = m_cnt + 1;
        m_sum = (m_sum + int'(b)) % 256;
        e.b = b; e.fend = 1'b0; e.csum = 1'b0;
`ifdef UART_TX_FEEDER_CHECKSUM_EN
        exp_q.push_back(e);
        if (m_cnt == FRAME_LEN) begin
            e.b = 8'(m_sum); e.fend = 1'b1; e.csum = 1'b1;
            exp_q.push_back(e);
            m_cnt = 0; m_sum = 0;
        end
`else
        if (m_cnt == FRAME_LEN) begin
            e.fend = 1'b1;
            m_cnt = 0; m_sum = 0;
        end
        exp_q.push_back(e);
`endif
    endtask

    task automatic wr(input logic [7:0] b, input bit accept);
        i_Wr_DV = 1'b1; i_Wr_Byte = b;
        if (accept) begin
            model_push(b);
            wr_total++;
        end
        @(posedge clk); #1;
        i_Wr_DV = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        i_Rst_n = 1'b0;
        exp_q.delete();
        m_cnt = 0; m_sum = 0; wr_total = 0;
        @(posedge clk); #3;
        chk("rst_tx_dv",      32'(o_Tx_DV), 0);
        chk("rst_tx_byte",    32'(o_Tx_Byte), 0);
        chk("rst_empty",      32'(o_Empty), 1);
        chk("rst_full",       32'(o_Full), 0);
        chk("rst_overflow",   32'(o_Overflow), 0);
        chk("rst_frame_done", 32'(o_Frame_Done), 0);
        i_Rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name, input int maxc);
        int c = 0;
        while ((exp_q.size() != 0 || xm_busy || xm_done || !o_Empty) && c < maxc) begin
            @(posedge clk); #1;
            c++;
        end
        chk({name, "_drain_in_time"}, 32'(c < maxc), 1);
    endtask

    // Transmitter model and scoreboard monitor.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            act_prev  = i_Tx_Active;
            done_prev = i_Tx_Done;
            @(posedge clk); #1;
            if (!i_Rst_n) begin
                payload_dv = 0;
                xm_flag    = 1'b0;
                fd_pending = 1'b0;
            end
            if (o_Frame_Done) fd_seen++;
            if (fd_pending) begin
                chk("frame_done_after_done", 32'(o_Frame_Done), 32'(fd_flag));
                if (fd_flag) fd_exp++;
                fd_pending = 1'b0;
            end
            if (xm_done) begin
                xm_done = 1'b0;
            end else if (xm_busy) begin
                xm_left--;
                if (xm_left <= 0) begin
                    xm_busy    = 1'b0;
                    xm_done    = 1'b1;
                    fd_pending = 1'b1;
                    fd_flag    = xm_flag;
                end
            end
            if (o_Tx_DV) begin
                dv_total++;
                chk("start_guard_idle", 32'({act_prev, done_prev}), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_tx_dv", 32'(o_Tx_Byte), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    $display("tx byte %02h (expected %02h, csum=%0d, frame_end=%0d)",
                             o_Tx_Byte, e.b, e.csum, e.fend);
                    chk("tx_byte", 32'(o_Tx_Byte), 32'(e.b));
                    if (!e.csum) payload_dv++;
                    xm_flag = e.fend;
                end
                xm_busy = 1'b1;
                xm_left = (xm_len_fixed != 0) ? xm_len_fixed : int'($urandom_range(1, 30));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int dv_before;
        int fd_before;
        // Single byte with latency checks.
        do_reset();
        i_Wr_DV = 1'b1; i_Wr_Byte = 8'hA5;
        model_push(8'hA5); wr_total++;
        @(posedge clk); #1;
        i_Wr_DV = 1'b0;
        chk("empty_falls_after_write", 32'(o_Empty), 0);
        @(posedge clk); #1;
        chk("first_dv_latency", 32'(o_Tx_DV), 1);
        chk("first_dv_byte", 32'(o_Tx_Byte), 32'hA5);
        drain("single", 400);
        chk("single_empty_after", 32'(o_Empty), 1);
        dv_before = dv_total;
        repeat (20) @(posedge clk);
        #1;
        chk("single_no_extra_dv", 32'(dv_total - dv_before), 0);

        // Burst past capacity with the transmitter stalled.
        hold_active = 1'b1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            wr(8'(i), i < DEPTH);
            if (i == DEPTH - 2) chk("not_full_at_15", 32'(o_Full), 0);
            if (i == DEPTH - 1) chk("full_at_16", 32'(o_Full), 1);
        end
        chk("overflow_sticky", 32'(o_Overflow), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("guard_holds_dv", 32'(o_Tx_DV), 0);
        // Release the guard while also writing into the still-full FIFO: the
        // write must be dropped even though a pop happens on the same edge.
        hold_active = 1'b0;
        wr(8'hEE, 1'b0);
        chk("dv_after_active_drops", 32'(o_Tx_DV), 1);
        chk("full_clears_after_pop", 32'(o_Full), 0);
        drain("burst", 5000);
        chk("overflow_still_set", 32'(o_Overflow), 1);

        // One full frame.
        do_reset();
        fd_before = fd_seen;
        wr(8'h01, 1'b1); wr(8'h02, 1'b1); wr(8'h03, 1'b1); wr(8'hFF, 1'b1);
        drain("frame", 2000);
        chk("frame_done_once", 32'(fd_seen - fd_before), 1);

        // Reset while a byte is on the wire.
        do_reset();
        wr(8'h11, 1'b1); wr(8'h22, 1'b1); wr(8'h33, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        chk("midxfer_tx_busy", 32'(xm_busy), 1);
        do_reset();
        wr(8'h5A, 1'b1); wr(8'hC3, 1'b1);
        drain("midxfer", 2000);

        // Randomized traffic with random transmitter durations.
        xm_len_fixed = 0;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            if ((wr_total - payload_dv) < DEPTH - 1 && $urandom_range(0, 3) != 0)
                wr(8'($urandom_range(0, 255)), 1'b1);
            else begin
                @(posedge clk); #1;
            end
        end
        drain("random", 8000);
        chk("random_no_overflow", 32'(o_Overflow), 0);
        chk("frame_done_count", 32'(fd_seen), 32'(fd_exp));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
